// File: rtl/txt_console_writer.sv
// Turns a CPU byte stream into text-mode display-memory writes at a tracked cursor.
// Define TXT_CONSOLE_TAB_EN to honour TAB (0x09) as an 8-column tab stop; otherwise it is dropped.
module txt_console_writer #(
    parameter int unsigned COLS  = 40,
    parameter int unsigned ROWS  = 30,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  char_data,
    input  logic        char_valid,
    output logic        char_ready,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [5:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CLR_LINE = 2'd1;
    localparam logic [1:0] ST_CLR_SCR  = 2'd2;

    localparam logic [5:0]  LAST_COL = 6'(COLS - 1);
    localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
    localparam logic [12:0] LINE_LEN = 13'(COLS);
    localparam logic [12:0] SCR_LEN  = 13'(COLS * ROWS);

    // Row start address; the default 40-column geometry uses row*32 + row*8.
    function automatic logic [11:0] row_base(input logic [4:0] r);
        logic [11:0] rw;
        rw = {7'd0, r};
        if (COLS == 40) return (rw << 5) + (rw << 3);
        else return rw * 12'(COLS);
    endfunction

    logic [1:0]  state_q, state_d;
    logic [12:0] cnt_q, cnt_d;
    logic [5:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic        wr_en_q, wr_en_d;
    logic [11:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        ready_q, ready_d;
    logic        busy_q;

    logic [11:0] cur_addr;
    logic [4:0]  next_row;
    logic        printable;
    logic        line_adv;

    assign cur_addr  = row_base(row_q) + {6'd0, col_q};
    assign next_row  = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
    assign printable = (char_data >= 8'h20) && (char_data <= 8'h7E);

`ifdef TXT_CONSOLE_TAB_EN
    logic [6:0] tab_col;
    assign tab_col = ({1'b0, col_q} | 7'd7) + 7'd1;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        col_d     = col_q;
        row_d     = row_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ready_d   = ready_q;
        line_adv  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (char_valid && ready_q) begin
                    if (printable) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cur_addr;
                        wr_data_d = char_data;
                        if (col_q == LAST_COL) begin
                            // Character lands first; the new row is blanked on following cycles.
                            col_d   = 6'd0;
                            row_d   = next_row;
                            cnt_d   = 13'd0;
                            state_d = ST_CLR_LINE;
                            ready_d = 1'b0;
                        end else begin
                            col_d = col_q + 6'd1;
                        end
                    end else begin
                        case (char_data)
                            8'h0D: col_d = 6'd0;
                            8'h0A: line_adv = 1'b1;
                            8'h08: begin
                                if (col_q != 6'd0) begin
                                    col_d     = col_q - 6'd1;
                                    wr_en_d   = 1'b1;
                                    wr_addr_d = cur_addr - 12'd1;
                                    wr_data_d = BLANK;
                                end
                            end
                            8'h0C: begin
                                col_d     = 6'd0;
                                row_d     = 5'd0;
                                wr_en_d   = 1'b1;
                                wr_addr_d = 12'd0;
                                wr_data_d = BLANK;
                                cnt_d     = 13'd1;
                                state_d   = ST_CLR_SCR;
                                ready_d   = 1'b0;
                            end
`ifdef TXT_CONSOLE_TAB_EN
                            8'h09: begin
                                if (tab_col >= 7'(COLS)) line_adv = 1'b1;
                                else col_d = tab_col[5:0];
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                // No character write of its own, so the first blank goes out right away.
                if (line_adv) begin
                    col_d     = 6'd0;
                    row_d     = next_row;
                    wr_en_d   = 1'b1;
                    wr_addr_d = row_base(next_row);
                    wr_data_d = BLANK;
                    cnt_d     = 13'd1;
                    state_d   = ST_CLR_LINE;
                    ready_d   = 1'b0;
                end
            end
            ST_CLR_LINE: begin
                if (cnt_q == LINE_LEN) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = row_base(row_q) + cnt_q[11:0];
                    wr_data_d = BLANK;
                    cnt_d     = cnt_q + 13'd1;
                end
            end
            ST_CLR_SCR: begin
                if (cnt_q == SCR_LEN) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    col_d   = 6'd0;
                    row_d   = 5'd0;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q[11:0];
                    wr_data_d = BLANK;
                    cnt_d     = cnt_q + 13'd1;
                end
            end
            default: begin
                state_d = ST_CLR_SCR;
                cnt_d   = 13'd0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLR_SCR;
            cnt_q     <= 13'd0;
            col_q     <= 6'd0;
            row_q     <= 5'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 12'd0;
            wr_data_q <= 8'd0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            row_q     <= row_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ready_q   <= ready_d;
            busy_q    <= ~ready_d;
        end
    end

    assign char_ready = ready_q;
    assign busy       = busy_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule

// File: tb/tb_txt_console_writer.sv
// Randomised self-checking bench for txt_console_writer against a cell/cursor reference model.
// Honours TXT_CONSOLE_TAB_EN the same way as the design.
module tb_txt_console_writer;

    localparam int COLS   = 40;
    localparam int ROWS   = 30;
    localparam int NCELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  char_data = 8'd0;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    txt_console_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(8'h20)) dut (
        .clk       (clk),
        .reset     (reset),
        .char_data (char_data),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cursor_col(cursor_col),
        .cursor_row(cursor_row),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: cursor, cycle of current acceptance, expected writes.
    int m_col = 0, m_row = 0, m_t = 0, m_n = 0, exp_busy = 0;
    int exp_addr[$], exp_data[$], exp_cyc[$];
    int obs_addr[$], obs_data[$], obs_cyc[$];
    int low_cnt;
    bit timeout;

    function automatic void exp_reset();
        exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
        m_t = 0;
    endfunction

    function automatic void exp_push(int a, int d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
        exp_cyc.push_back(m_t + 1 + m_n);
        m_n++;
    endfunction

    function automatic void advance_row();
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        for (int i = 0; i < COLS; i++) exp_push(m_row * COLS + i, 8'h20);
        exp_busy += COLS;
    endfunction

    function automatic void model_char(input logic [7:0] c);
        m_n = 0;
        exp_busy = 0;
        if (c >= 8'h20 && c <= 8'h7E) begin
            exp_push(m_row * COLS + m_col, c);
            if (m_col == COLS - 1) begin
                exp_busy = 1;
                advance_row();
            end else begin
                m_col++;
            end
        end else if (c == 8'h0D) begin
            m_col = 0;
        end else if (c == 8'h0A) begin
            advance_row();
        end else if (c == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                exp_push(m_row * COLS + m_col, 8'h20);
            end
        end else if (c == 8'h0C) begin
            m_col = 0;
            m_row = 0;
            for (int i = 0; i < NCELLS; i++) exp_push(i, 8'h20);
            exp_busy = NCELLS;
        end
`ifdef TXT_CONSOLE_TAB_EN
        else if (c == 8'h09) begin
            if ((m_col | 7) + 1 >= COLS) advance_row();
            else m_col = (m_col | 7) + 1;
        end
`endif
        // A held follow-on character is accepted in the first cycle ready is seen high.
        m_t = m_t + exp_busy + 1;
    endfunction

    function automatic void record(int k);
        if (wr_en) begin
            obs_addr.push_back(int'(wr_addr));
            obs_data.push_back(int'(wr_data));
            obs_cyc.push_back(k);
        end
    endfunction

    function automatic int write_diff();
        int n;
        n = (obs_addr.size() > exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            if (i >= obs_addr.size() || i >= exp_addr.size()) return i;
            if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i] ||
                obs_cyc[i] != exp_cyc[i]) return i;
        end
        return -1;
    endfunction

    function automatic string wdesc(bit use_obs, int i);
        if (use_obs) begin
            if (i >= obs_addr.size()) return "none";
            return $sformatf("addr=%0d data=%h cyc=%0d", obs_addr[i], obs_data[i], obs_cyc[i]);
        end
        if (i >= exp_addr.size()) return "none";
        return $sformatf("addr=%0d data=%h cyc=%0d", exp_addr[i], exp_data[i], exp_cyc[i]);
    endfunction

    // Collects writes from the cycle after acceptance until ready is seen high again.
    task automatic capture(input int max_cyc);
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
        low_cnt = 0;
        timeout = 1'b1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            if (k == 1) char_valid = 1'b0;
            record(k);
            if (char_ready) begin
                timeout = 1'b0;
                break;
            end
            low_cnt++;
        end
    endtask

    task automatic send_char(input logic [7:0] c);
        int w;
        w = 0;
        while (!char_ready && w < 5000) begin
            @(negedge clk);
            w++;
        end
        char_data  = c;
        char_valid = 1'b1;
        capture(NCELLS + 50);
    endtask

    task automatic step(input logic [7:0] c);
        exp_reset();
        model_char(c);
        send_char(c);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        char_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_data} !== 21'd0)
            $display("FAIL reset_wr: got en=%b addr=%0d data=%h, need 0/0/00", wr_en, wr_addr, wr_data);
        else passes++;
        checks++;
        if (char_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL reset_ready: got ready=%b busy=%b, need 0/1", char_ready, busy);
        else passes++;
        checks++;
        if ({cursor_row, cursor_col} !== 11'd0)
            $display("FAIL reset_cursor: got (%0d,%0d), need (0,0)", cursor_row, cursor_col);
        else passes++;
        reset = 1'b0;
        m_col = 0;
        m_row = 0;
        exp_reset();
        model_char(8'h0C);
        capture(NCELLS + 50);
        checks++;
        if (write_diff() >= 0)
            $display("FAIL reset_clear_writes: at %0d got %s (%0d writes), need %s (%0d writes)",
                     write_diff(), wdesc(1, write_diff()), obs_addr.size(),
                     wdesc(0, write_diff()), exp_addr.size());
        else passes++;
        checks++;
        if (timeout || low_cnt != exp_busy || busy !== 1'b0)
            $display("FAIL reset_clear_ready: got %0d low cycles busy=%b, need %0d busy=0",
                     low_cnt, busy, exp_busy);
        else passes++;
    endtask

    task automatic test_back_to_back();
        exp_reset();
        model_char(8'h41);
        model_char(8'h42);
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
        char_data  = 8'h41;
        char_valid = 1'b1;
        @(negedge clk);
        record(1);
        checks++;
        if (char_ready !== 1'b1) $display("FAIL b2b_ready: got %b, need 1", char_ready);
        else passes++;
        char_data = 8'h42;
        @(negedge clk);
        record(2);
        char_valid = 1'b0;
        @(negedge clk);
        record(3);
        checks++;
        if (write_diff() >= 0)
            $display("FAIL b2b_writes: at %0d got %s, need %s", write_diff(),
                     wdesc(1, write_diff()), wdesc(0, write_diff()));
        else passes++;
        checks++;
        if ({cursor_row, cursor_col} !== {5'(m_row), 6'(m_col)} || char_ready !== 1'b1)
            $display("FAIL b2b_cursor: got (%0d,%0d) ready=%b, need (%0d,%0d) ready=1",
                     cursor_row, cursor_col, char_ready, m_row, m_col);
        else passes++;
    endtask

    // Sends one code and compares writes, ready-low time and cursor with the model.
    task automatic check_char(input logic [7:0] c, input string name);
        step(c);
        checks++;
        if (write_diff() >= 0 || timeout || low_cnt != exp_busy)
            $display("FAIL %s_writes: at %0d got %s (%0d writes, %0d low), need %s (%0d, %0d low)",
                     name, write_diff(), wdesc(1, write_diff()), obs_addr.size(), low_cnt,
                     wdesc(0, write_diff()), exp_addr.size(), exp_busy);
        else passes++;
        checks++;
        if ({cursor_row, cursor_col} !== {5'(m_row), 6'(m_col)})
            $display("FAIL %s_cursor: got (%0d,%0d), need (%0d,%0d)",
                     name, cursor_row, cursor_col, m_row, m_col);
        else passes++;
    endtask

    task automatic test_wrap();
        step(8'h0D);
        repeat (29) step(8'h0A);
        repeat (39) step(8'h61);
        checks++;
        if ({cursor_row, cursor_col} !== {5'd29, 6'd39})
            $display("FAIL wrap_setup: got (%0d,%0d), need (29,39)", cursor_row, cursor_col);
        else passes++;
        check_char(8'h5A, "wrap");
    endtask

    task automatic test_backspace();
        step(8'h0D);
        repeat (3) step(8'h0A);
        repeat (5) step(8'h62);
        check_char(8'h08, "bs_write");
        check_char(8'h0D, "cr");
        check_char(8'h08, "bs_col0");
    endtask

    task automatic test_linefeed();
        check_char(8'h0C, "ff");
        repeat (2) step(8'h0A);
        repeat (10) step(8'h63);
        check_char(8'h0A, "lf");
        check_char(8'h07, "drop");
    endtask

    task automatic test_hold();
        bit pend;
        exp_reset();
        model_char(8'h0A);
        model_char(8'h48);
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
        char_data  = 8'h0A;
        char_valid = 1'b1;
        @(negedge clk);
        record(1);
        char_data = 8'h48;
        pend = 1'b0;
        for (int k = 2; k <= 80; k++) begin
            @(negedge clk);
            record(k);
            if (pend) char_valid = 1'b0;
            pend = char_valid && char_ready;
        end
        char_valid = 1'b0;
        checks++;
        if (write_diff() >= 0)
            $display("FAIL hold_writes: at %0d got %s (%0d writes), need %s (%0d writes)",
                     write_diff(), wdesc(1, write_diff()), obs_addr.size(),
                     wdesc(0, write_diff()), exp_addr.size());
        else passes++;
    endtask

    task automatic test_reset_mid_clear();
        char_data  = 8'h0A;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (wr_en !== 1'b1 || char_ready !== 1'b0)
            $display("FAIL midclr_active: got en=%b ready=%b, need 1/0", wr_en, char_ready);
        else passes++;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || char_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL midclr_reset: got en=%b ready=%b busy=%b, need 0/0/1",
                     wr_en, char_ready, busy);
        else passes++;
        reset = 1'b0;
        m_col = 0;
        m_row = 0;
        exp_reset();
        model_char(8'h0C);
        capture(NCELLS + 50);
        checks++;
        if (write_diff() >= 0 || timeout || low_cnt != exp_busy)
            $display("FAIL midclr_restart: at %0d got %s (%0d low), need %s (%0d low)",
                     write_diff(), wdesc(1, write_diff()), low_cnt,
                     wdesc(0, write_diff()), exp_busy);
        else passes++;
    endtask

    task automatic test_tab();
        step(8'h0D);
        repeat (37) step(8'h64);
        check_char(8'h09, "tab_wrap");
        step(8'h0D);
        check_char(8'h09, "tab_col0");
    endtask

    task automatic test_random();
        logic [7:0] others [5];
        logic [7:0] c;
        int r;
        others = '{8'h00, 8'h07, 8'h7F, 8'h1B, 8'hFF};
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(99);
            if (r < 65) c = 8'($urandom_range(8'h7E, 8'h20));
            else if (r < 72) c = 8'h0D;
            else if (r < 80) c = 8'h0A;
            else if (r < 90) c = 8'h08;
            else if (r < 95) c = others[$urandom_range(4)];
            else c = 8'h09;
            check_char(c, $sformatf("rand%0d_%h", i, c));
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_wrap();
        test_backspace();
        test_linefeed();
        test_hold();
        test_tab();
        test_random();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
